// File: rtl/control_multicycle_if.sv
// ---------------------------------------------------------------------------
// control_multicycle_if
//   Bundle between the multi-cycle control FSM and the datapath/memory.
//   master : the control unit (drives strobes and mux selects, reads status)
//   slave  : the datapath side (drives opcode/zero/mem_ready, reads controls)
//
//   opcode      instr[6:0] from IR             (datapath -> control)
//   zero        ALU zero flag                  (datapath -> control)
//   mem_ready   memory finishes access         (memory   -> control)
//   mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
//   result_src, alu_src_a, alu_src_b, imm_src, alu_op  (control -> datapath)
//   state, instr_done, trap, trap_cause              (control status/debug)
// ---------------------------------------------------------------------------
interface control_multicycle_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [1:0] alu_op;
  logic [3:0] state;
  logic       instr_done;
  logic       trap;
  logic       trap_cause;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_op,
           state, instr_done, trap, trap_cause
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_op,
           state, instr_done, trap, trap_cause
  );
endinterface

// File: rtl/control_multicycle_fsm.sv
// ---------------------------------------------------------------------------
// control_multicycle_fsm
//   Moore-style control unit for a shared-memory multi-cycle RISC-V datapath.
//   Sequences fetch/decode/execute/writeback, waits on a memory handshake
//   with a bounded wait counter, traps on illegal opcodes or memory timeout,
//   and pulses instr_done when an instruction retires.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    control_multicycle_if.master (see interface for signal list)
//
//   Parameters
//     WAIT_W   width of the memory wait counter
//     TIMEOUT  wait cycles allowed per access before trapping; 0 disables
//              the timeout; must be < 2**WAIT_W
//
//   Build option
//     MC_CTRL_UTYPE_EN  when defined, lui/auipc execute through the UTYPE
//                       state; otherwise they trap as illegal opcodes.
// ---------------------------------------------------------------------------
module control_multicycle_fsm #(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  control_multicycle_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11,
    S_UTYPE    = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_RTYPE  = 7'd51;
  localparam logic [6:0] OP_ITYPE  = 7'd19;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;

  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              trap_cause_q, trap_cause_d;

  // Raw control values; strobes are gated by rst_n below.
  logic       mem_req_c, adr_src_c, ir_write_c, mem_write_c, reg_write_c;
  logic       pc_update_c, branch_c, instr_done_c, trap_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
  logic [2:0] imm_src_c;
  logic       wait_state;
  logic       timed_out;

  // Timeout fires only while the access is still pending; a mem_ready in the
  // same cycle completes the access instead.
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                      (state_q == S_MEMWRITE);
  assign timed_out  = (TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_V) &&
                      !bus.mem_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    trap_cause_d = trap_cause_q;
    mem_req_c    = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    pc_update_c  = 1'b0;
    branch_c     = 1'b0;
    instr_done_c = 1'b0;
    trap_c       = 1'b0;
    result_src_c = 2'b00;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;

    // Immediate format depends on the opcode alone, not on the state.
    case (bus.opcode)
      OP_STORE:         imm_src_c = 3'b001;
      OP_BRANCH:        imm_src_c = 3'b010;
      OP_JAL:           imm_src_c = 3'b011;
      OP_LUI, OP_AUIPC: imm_src_c = 3'b100;
      default:          imm_src_c = 3'b000;
    endcase

    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        if (bus.mem_ready) begin
          ir_write_c  = 1'b1;
          pc_update_c = 1'b1;
          state_d     = S_DECODE;
        end else if (timed_out) begin
          state_d      = S_TRAP;
          trap_cause_d = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef MC_CTRL_UTYPE_EN
          OP_LUI, OP_AUIPC:  state_d = S_UTYPE;
`endif
          default: begin
            state_d      = S_TRAP;
            trap_cause_d = 1'b0;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        if (bus.opcode == OP_LOAD)       state_d = S_MEMREAD;
        else if (bus.opcode == OP_STORE) state_d = S_MEMWRITE;
        else                             state_d = S_FETCH;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else if (timed_out) begin
          state_d      = S_TRAP;
          trap_cause_d = 1'b1;
        end
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        // Write strobe is held for the whole access, including the ready cycle.
        mem_req_c   = 1'b1;
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (bus.mem_ready) begin
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end else if (timed_out) begin
          state_d      = S_TRAP;
          trap_cause_d = 1'b1;
        end
      end
      S_EXECR: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op_c    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_c  = 2'b10;
        alu_op_c     = 2'b01;
        branch_c     = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target computed in DECODE; rd gets OldPC+4 in ALUWB.
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_update_c = 1'b1;
        state_d     = S_ALUWB;
      end
      S_TRAP: begin
        trap_c  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MC_CTRL_UTYPE_EN
      S_UTYPE: begin
        alu_src_a_c = (bus.opcode == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b_c = 2'b01;
        state_d     = S_ALUWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Counter restarts whenever the state changes, so each access starts at 0.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (wait_state && !bus.mem_ready && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= '0;
      trap_cause_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // Strobes are masked by rst_n so an asserted reset kills any in-flight
  // write immediately rather than at the next clock edge.
  assign bus.mem_req    = rst_n & mem_req_c;
  assign bus.ir_write   = rst_n & ir_write_c;
  assign bus.pc_write   = rst_n & (pc_update_c | (branch_c & bus.zero));
  assign bus.mem_write  = rst_n & mem_write_c;
  assign bus.reg_write  = rst_n & reg_write_c;
  assign bus.instr_done = rst_n & instr_done_c;
  assign bus.trap       = rst_n & trap_c;
  assign bus.adr_src    = adr_src_c;
  assign bus.result_src = result_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.imm_src    = imm_src_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.state      = state_q;
  assign bus.trap_cause = trap_cause_q;

endmodule

// File: tb/tb_control_multicycle_fsm.sv
// ---------------------------------------------------------------------------
// tb_control_multicycle_fsm
//   Scoreboard bench: each directed instruction pushes a hand-computed
//   per-instruction profile; a monitor accumulates DUT activity every cycle
//   and compares on each instr_done / trap pulse. A simple memory model
//   answers mem_req with a programmable number of wait cycles.
// ---------------------------------------------------------------------------
module tb_control_multicycle_fsm;

  logic clk;
  logic rst_n;
  control_multicycle_if bus ();

  control_multicycle_fsm #(.WAIT_W(4), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    int         st;     // state at the retire/trap pulse
    int         cyc;    // cycles from first FETCH through the pulse
    int         req;    // cycles with mem_req
    int         adr;    // cycles with mem_req and adr_src=1
    int         ir;     // ir_write cycles
    int         pc;     // pc_write cycles
    int         mem;    // mem_write cycles
    int         rg;     // reg_write cycles
    logic [1:0] wb;     // result_src during reg_write (11 = none)
    logic [2:0] imm;    // imm_src seen in DECODE (111 = never decoded)
    logic [5:0] x3;     // {alu_src_a,alu_src_b,alu_op} right after DECODE
    logic       tr;     // trap pulse
    logic       cause;  // trap_cause at the pulse
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   events_seen = 0;
  int   fetch_wait = 0;
  int   data_wait  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input int st, input int cyc, input int req,
                              input int adr, input int ir, input int pc, input int mem,
                              input int rg, input logic [1:0] wb, input logic [2:0] imm,
                              input logic [5:0] x3, input logic tr, input logic cause);
    exp_t e;
    e.name = n; e.st = st; e.cyc = cyc; e.req = req; e.adr = adr; e.ir = ir;
    e.pc = pc; e.mem = mem; e.rg = rg; e.wb = wb; e.imm = imm; e.x3 = x3;
    e.tr = tr; e.cause = cause;
    return e;
  endfunction

  // Memory model: inputs change 2 time units after the edge.
  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_req && !bus.adr_src && fetch_wait > 0) begin
        bus.mem_ready = 1'b0;
        fetch_wait--;
      end else if (bus.mem_req && bus.adr_src && data_wait > 0) begin
        bus.mem_ready = 1'b0;
        data_wait--;
      end else begin
        bus.mem_ready = 1'b1;
      end
    end
  end

  // Monitor: sample on the falling edge, compare on every retire/trap pulse.
  initial begin
    int cyc, req, adr, ir, pc, mem, rg;
    logic [1:0] wb;
    logic [2:0] imm;
    logic [5:0] x3;
    logic prev_dec;
    exp_t e;
    cyc = 0; req = 0; adr = 0; ir = 0; pc = 0; mem = 0; rg = 0;
    wb = 2'b11; imm = 3'b111; x3 = 6'h3F; prev_dec = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0; req = 0; adr = 0; ir = 0; pc = 0; mem = 0; rg = 0;
        wb = 2'b11; imm = 3'b111; x3 = 6'h3F; prev_dec = 1'b0;
      end else begin
        cyc++;
        req += int'(bus.mem_req);
        adr += int'(bus.mem_req & bus.adr_src);
        ir  += int'(bus.ir_write);
        pc  += int'(bus.pc_write);
        mem += int'(bus.mem_write);
        rg  += int'(bus.reg_write);
        if (bus.reg_write) wb = bus.result_src;
        if (bus.state == 4'd1) imm = bus.imm_src;
        if (prev_dec) x3 = {bus.alu_src_a, bus.alu_src_b, bus.alu_op};
        prev_dec = (bus.state == 4'd1);
        if (bus.instr_done || bus.trap) begin
          events_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_event", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check({e.name, ".state"},      bus.state, e.st);
            check({e.name, ".cycles"},     cyc,   e.cyc);
            check({e.name, ".mem_req"},    req,   e.req);
            check({e.name, ".adr_src"},    adr,   e.adr);
            check({e.name, ".ir_write"},   ir,    e.ir);
            check({e.name, ".pc_write"},   pc,    e.pc);
            check({e.name, ".mem_write"},  mem,   e.mem);
            check({e.name, ".reg_write"},  rg,    e.rg);
            check({e.name, ".result_src"}, wb,    e.wb);
            check({e.name, ".imm_src"},    imm,   e.imm);
            check({e.name, ".exec_mux"},   x3,    e.x3);
            check({e.name, ".trap"},       bus.trap, e.tr);
            check({e.name, ".trap_cause"}, bus.trap_cause, e.cause);
          end
          cyc = 0; req = 0; adr = 0; ir = 0; pc = 0; mem = 0; rg = 0;
          wb = 2'b11; imm = 3'b111; x3 = 6'h3F;
        end
      end
    end
  end

  // Called at posedge+1 of the cycle where the instruction's FETCH begins.
  task automatic issue(input logic [6:0] op, input logic z, input int fw, input int dw,
                       input exp_t e);
    int start;
    bit seen;
    bus.opcode = op;
    bus.zero   = z;
    fetch_wait = fw;
    data_wait  = dw;
    exp_q.push_back(e);
    start = events_seen;
    seen  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      if (events_seen != start) begin
        seen = 1'b1;
        break;
      end
    end
    check({e.name, ".completed"}, seen, 1);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".state"},      bus.state, 0);
    check({tag, ".mem_req"},    bus.mem_req, 0);
    check({tag, ".mem_write"},  bus.mem_write, 0);
    check({tag, ".reg_write"},  bus.reg_write, 0);
    check({tag, ".pc_write"},   bus.pc_write, 0);
    check({tag, ".ir_write"},   bus.ir_write, 0);
    check({tag, ".instr_done"}, bus.instr_done, 0);
    check({tag, ".trap"},       bus.trap, 0);
    check({tag, ".trap_cause"}, bus.trap_cause, 0);
  endtask

  initial begin
    bit wr_seen;
    rst_n      = 1'b0;
    bus.opcode = 7'd0;
    bus.zero   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    //                        st cyc req adr ir pc mem rg wb     imm     x3          tr cause
    issue(7'd3,   0, 0, 0,   mk("lw",        4, 5,  2, 1, 1, 1, 0, 1, 2'b01, 3'b000, 6'b10_01_00, 0, 0));
    issue(7'd35,  0, 0, 3,   mk("sw_wait3",  5, 7,  5, 4, 1, 1, 4, 0, 2'b11, 3'b001, 6'b10_01_00, 0, 0));
    issue(7'd99,  1, 0, 0,   mk("beq_taken", 9, 3,  1, 0, 1, 2, 0, 0, 2'b11, 3'b010, 6'b10_00_01, 0, 0));
    issue(7'd99,  0, 0, 0,   mk("beq_not",   9, 3,  1, 0, 1, 1, 0, 0, 2'b11, 3'b010, 6'b10_00_01, 0, 0));
    issue(7'd111, 0, 0, 0,   mk("jal",       8, 4,  1, 0, 1, 2, 0, 1, 2'b00, 3'b011, 6'b01_10_00, 0, 0));
    issue(7'd51,  0, 0, 0,   mk("rtype",     8, 4,  1, 0, 1, 1, 0, 1, 2'b00, 3'b000, 6'b10_00_10, 0, 0));
    issue(7'd19,  0, 0, 0,   mk("itype",     8, 4,  1, 0, 1, 1, 0, 1, 2'b00, 3'b000, 6'b10_01_10, 0, 0));
    issue(7'd3,   0, 2, 1,   mk("lw_waits",  4, 8,  5, 2, 1, 1, 0, 1, 2'b01, 3'b000, 6'b10_01_00, 0, 0));
    issue(7'd3,   0, 100, 0, mk("fetch_to", 11, 17, 16, 0, 0, 0, 0, 0, 2'b11, 3'b111, 6'h3F,       1, 1));
    issue(7'd3,   0, 0, 0,   mk("lw_held",   4, 5,  2, 1, 1, 1, 0, 1, 2'b01, 3'b000, 6'b10_01_00, 0, 1));
    issue(7'h7F,  0, 0, 0,   mk("illegal",  11, 3,  1, 0, 1, 1, 0, 0, 2'b11, 3'b000, 6'b00_00_00, 1, 0));
    issue(7'd35,  0, 0, 15,  mk("sw_edge",   5, 19, 17, 16, 1, 1, 16, 0, 2'b11, 3'b001, 6'b10_01_00, 0, 0));
    issue(7'd35,  0, 0, 100, mk("sw_to",    11, 20, 17, 16, 1, 1, 16, 0, 2'b11, 3'b001, 6'b10_01_00, 1, 1));
`ifdef MC_CTRL_UTYPE_EN
    issue(7'd55,  0, 0, 0,   mk("lui",       8, 4,  1, 0, 1, 1, 0, 1, 2'b00, 3'b100, 6'b11_01_00, 0, 1));
`else
    issue(7'd55,  0, 0, 0,   mk("lui",      11, 3,  1, 0, 1, 1, 0, 0, 2'b11, 3'b100, 6'b00_00_00, 1, 0));
`endif

    // Asynchronous reset in the middle of a stalled store.
    bus.opcode = 7'd35;
    fetch_wait = 0;
    data_wait  = 100;
    wr_seen    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #3;
      if (bus.mem_write) begin
        wr_seen = 1'b1;
        break;
      end
    end
    check("midreset.mem_write_seen", wr_seen, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(7'd3,   0, 0, 0,   mk("lw_after",  4, 5,  2, 1, 1, 1, 0, 1, 2'b01, 3'b000, 6'b10_01_00, 0, 0));

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
